// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
//
// Pixel-clock video timing generator and test-pattern source feeding the
// three TMDS channel encoders of the HDMI transmitter. Produces hsync, vsync,
// DE and a 24-bit RGB stream, all registered once from the h/v counters so
// they arrive mutually aligned. Default geometry is 640x480@60.
//
// Ports
//   pclk         in   pixel clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   run enable; low clears counters and blanks outputs
//   pat_sel[1:0] in   0 colour bars, 1 gradient, 2 checkerboard, 3 solid
//   solid_rgb    in   colour used by the solid pattern
//   hsync        out  horizontal sync (active level = SYNC_POL)
//   vsync        out  vertical sync (active level = SYNC_POL)
//   de           out  data enable
//   rgb[23:0]    out  pixel {R, G, B}, zero outside the active area
//   frame_start  out  one-cycle pulse on the first active pixel of a frame
// ---------------------------------------------------------------------------
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] BAR_LAST = 12'(BAR_W - 1);

    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);

    localparam logic SYNC_ON = 1'(SYNC_POL);

    logic [11:0] h_cnt;
    logic [10:0] v_cnt;
    logic [11:0] bar_px;
    logic [2:0]  bar_idx;
    logic [1:0]  pat_q;
    logic [23:0] solid_q;

    logic        h_wrap, v_wrap;
    logic        h_act, v_act, de_next;
    logic        hs_next, vs_next, fs_next;
    logic [7:0]  grad_b;
    logic [23:0] bar_rgb, pat_rgb, rgb_next;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Pixel and line counters; en low has priority and parks both at 0.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
            if (h_wrap)
                v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
        end
    end

    // Bar index tracks h_cnt: it steps every BAR_W active pixels and holds at
    // 7 so the last bar soaks up any H_ACTIVE remainder.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!en || h_wrap) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (h_act) begin
            if (bar_px == BAR_LAST) begin
                bar_px <= '0;
                if (bar_idx != 3'd7)
                    bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 12'd1;
            end
        end
    end

    // Pattern controls are latched on the last pixel of a frame so a frame
    // never mixes two patterns. They survive en low.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q   <= 2'd0;
            solid_q <= 24'h0;
        end else if (en && h_wrap && v_wrap) begin
            pat_q   <= pat_sel;
            solid_q <= solid_rgb;
        end
    end

    assign h_act   = (h_cnt < H_ACT);
    assign v_act   = (v_cnt < V_ACT);
    assign de_next = h_act & v_act;
    assign hs_next = (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_ON : ~SYNC_ON;
    assign vs_next = (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_ON : ~SYNC_ON;
    assign fs_next = (h_cnt == 12'd0) && (v_cnt == 11'd0);
    assign grad_b  = h_cnt[7:0] + v_cnt[7:0];

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pat_rgb = 24'h000000;
        case (pat_q)
            2'd0:    pat_rgb = bar_rgb;
            2'd1:    pat_rgb = {h_cnt[7:0], v_cnt[7:0], grad_b};
            2'd2:    pat_rgb = (h_cnt[5] ^ v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
            default: pat_rgb = solid_q;
        endcase
    end

    assign rgb_next = de_next ? pat_rgb : 24'h000000;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            rgb         <= 24'h0;
            frame_start <= 1'b0;
        end else if (!en) begin
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            de          <= 1'b0;
            rgb         <= 24'h0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_next;
            vsync       <= vs_next;
            de          <= de_next;
            rgb         <= rgb_next;
            frame_start <= fs_next;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int HA  = 100;
    localparam int HFP = 4;
    localparam int HSW = 8;
    localparam int HBP = 6;
    localparam int VA  = 40;
    localparam int VFP = 2;
    localparam int VSW = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;
    localparam int BW  = HA / 8;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic        fs;
    } out_t;

    localparam out_t RST0 = {1'b1, 1'b1, 1'b0, 24'h0, 1'b0};
    localparam out_t RST1 = {1'b0, 1'b0, 1'b0, 24'h0, 1'b0};

    logic        pclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;

    logic        hsync0, vsync0, de0, fs0;
    logic [23:0] rgb0;
    logic        hsync1, vsync1, de1, fs1;
    logic [23:0] rgb1;

    out_t obs0, obs1;
    assign obs0 = {hsync0, vsync0, de0, rgb0, fs0};
    assign obs1 = {hsync1, vsync1, de1, rgb1, fs1};

    always #5 pclk = ~pclk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(0)
    ) dut0 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hsync(hsync0), .vsync(vsync0), .de(de0), .rgb(rgb0), .frame_start(fs0)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(1)
    ) dut1 (
        .pclk(pclk), .rst_n(rst_n), .en(en), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .hsync(hsync1), .vsync(vsync1), .de(de1), .rgb(rgb1), .frame_start(fs1)
    );

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    int total = 0;
    int bad   = 0;

    // Reference model: position within the frame as a flat cycle index.
    int          t      = 0;
    int          last_t = 0;
    logic [1:0]  sh_pat = 2'd0;
    logic [23:0] sh_col = 24'h0;
    out_t        q0[$];
    out_t        q1[$];
    out_t        e0, e1;

    function automatic out_t model_out(int tt, logic [1:0] pat, logic [23:0] col, logic pol);
        int   x, y, b;
        out_t o;
        x = tt % HT;
        y = tt / HT;
        o.hs  = (x >= HA + HFP && x < HA + HFP + HSW) ? pol : ~pol;
        o.vs  = (y >= VA + VFP && y < VA + VFP + VSW) ? pol : ~pol;
        o.de  = (x < HA) && (y < VA);
        o.fs  = (tt == 0);
        o.rgb = 24'h0;
        if (o.de) begin
            case (pat)
                2'd0: begin
                    b = x / BW;
                    if (b > 7) b = 7;
                    o.rgb = bar_tab[b];
                end
                2'd1: o.rgb = {8'(x), 8'(y), 8'(x + y)};
                2'd2: o.rgb = (((x >> 5) ^ (y >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                default: o.rgb = col;
            endcase
        end
        return o;
    endfunction

    // Push what the DUTs must show after the coming edge, advance the model,
    // then step to just after that edge.
    task automatic tick();
        if (en) begin
            q0.push_back(model_out(t, sh_pat, sh_col, 1'b0));
            q1.push_back(model_out(t, sh_pat, sh_col, 1'b1));
        end else begin
            q0.push_back(RST0);
            q1.push_back(RST1);
        end
        last_t = en ? t : -1;
        if (!en) begin
            t = 0;
        end else begin
            if (t == FT - 1) begin
                sh_pat = pat_sel;
                sh_col = solid_rgb;
            end
            t = (t + 1) % FT;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; pat_sel = 2'd0; solid_rgb = 24'h0;
        repeat (3) @(posedge pclk);
        #1;
        total++;
        if (obs0 !== RST0) begin bad++; $display("FAIL reset_pol0 got=%h exp=%h", obs0, RST0); end
        total++;
        if (obs1 !== RST1) begin bad++; $display("FAIL reset_pol1 got=%h exp=%h", obs1, RST1); end
        rst_n = 1'b1;
        t = 0; sh_pat = 2'd0; sh_col = 24'h0;
    endtask

    task automatic test_bars();
        int n_hs0, n_hs1, n_vs0, n_de, n_fs;
        bit do_spot;
        logic [24:0] spot;
        n_hs0 = 0; n_hs1 = 0; n_vs0 = 0; n_de = 0; n_fs = 0;
        for (int i = 0; i < FT; i++) begin
            if (i == FT / 2) begin pat_sel = 2'd1; solid_rgb = 24'h123456; end
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL bars_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
            if (hsync0 === 1'b0) n_hs0++;
            if (hsync1 === 1'b1) n_hs1++;
            if (vsync0 === 1'b0) n_vs0++;
            if (de0 === 1'b1) n_de++;
            if (fs0 === 1'b1) n_fs++;
            do_spot = 1'b0; spot = '0;
            case (last_t)
                0:           begin do_spot = 1'b1; spot = {1'b1, 24'hFFFFFF}; end
                BW - 1:      begin do_spot = 1'b1; spot = {1'b1, 24'hFFFFFF}; end
                BW:          begin do_spot = 1'b1; spot = {1'b1, 24'hFFFF00}; end
                7 * BW - 1:  begin do_spot = 1'b1; spot = {1'b1, 24'h0000FF}; end
                HA - 1:      begin do_spot = 1'b1; spot = {1'b1, 24'h000000}; end
                HA:          begin do_spot = 1'b1; spot = {1'b0, 24'h000000}; end
                30 * HT + 2 * BW: begin do_spot = 1'b1; spot = {1'b1, 24'h00FFFF}; end
                default: ;
            endcase
            if (do_spot) begin
                total++;
                if ({de0, rgb0} !== spot) begin
                    bad++; $display("FAIL bars_spot t=%0d got=%h exp=%h", last_t, {de0, rgb0}, spot);
                end
            end
        end
        total++;
        if (n_hs0 != HSW * VT) begin bad++; $display("FAIL hsync_width got=%0d exp=%0d", n_hs0, HSW * VT); end
        total++;
        if (n_hs1 != HSW * VT) begin bad++; $display("FAIL hsync_width_pol1 got=%0d exp=%0d", n_hs1, HSW * VT); end
        total++;
        if (n_vs0 != VSW * HT) begin bad++; $display("FAIL vsync_width got=%0d exp=%0d", n_vs0, VSW * HT); end
        total++;
        if (n_de != HA * VA) begin bad++; $display("FAIL de_count got=%0d exp=%0d", n_de, HA * VA); end
        total++;
        if (n_fs != 1) begin bad++; $display("FAIL frame_start_count got=%0d exp=1", n_fs); end
    endtask

    task automatic test_gradient();
        bit do_spot;
        logic [25:0] spot;
        for (int i = 0; i < FT; i++) begin
            if (i == FT / 2) pat_sel = 2'd2;
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL grad_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
            do_spot = 1'b0; spot = '0;
            case (last_t)
                0:            begin do_spot = 1'b1; spot = {1'b1, 1'b1, 24'h000000}; end
                3 * HT + 30:  begin do_spot = 1'b1; spot = {1'b1, 1'b0, 24'h1E0321}; end
                39 * HT + 99: begin do_spot = 1'b1; spot = {1'b1, 1'b0, 24'h63278A}; end
                default: ;
            endcase
            if (do_spot) begin
                total++;
                if ({de0, fs0, rgb0} !== spot) begin
                    bad++; $display("FAIL grad_spot t=%0d got=%h exp=%h", last_t, {de0, fs0, rgb0}, spot);
                end
            end
        end
    endtask

    task automatic test_checker();
        bit do_spot;
        logic [24:0] spot;
        for (int i = 0; i < FT; i++) begin
            if (i == FT / 2) begin pat_sel = 2'd3; solid_rgb = 24'h123456; end
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL chk_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
            do_spot = 1'b0; spot = '0;
            case (last_t)
                0:            begin do_spot = 1'b1; spot = {1'b1, 24'h000000}; end
                31:           begin do_spot = 1'b1; spot = {1'b1, 24'h000000}; end
                32:           begin do_spot = 1'b1; spot = {1'b1, 24'hFFFFFF}; end
                32 * HT:      begin do_spot = 1'b1; spot = {1'b1, 24'hFFFFFF}; end
                32 * HT + 32: begin do_spot = 1'b1; spot = {1'b1, 24'h000000}; end
                default: ;
            endcase
            if (do_spot) begin
                total++;
                if ({de0, rgb0} !== spot) begin
                    bad++; $display("FAIL chk_spot t=%0d got=%h exp=%h", last_t, {de0, rgb0}, spot);
                end
            end
        end
    endtask

    task automatic test_solid();
        bit do_spot;
        logic [24:0] spot;
        for (int i = 0; i < FT; i++) begin
            if (i == FT / 2) solid_rgb = 24'hABCDEF;
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL solid_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
            do_spot = 1'b0; spot = '0;
            case (last_t)
                0:            begin do_spot = 1'b1; spot = {1'b1, 24'h123456}; end
                39 * HT + 99: begin do_spot = 1'b1; spot = {1'b1, 24'h123456}; end
                default: ;
            endcase
            if (do_spot) begin
                total++;
                if ({de0, rgb0} !== spot) begin
                    bad++; $display("FAIL solid_spot t=%0d got=%h exp=%h", last_t, {de0, rgb0}, spot);
                end
            end
        end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 10 * HT + 20; i++) begin
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL en_run_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
            if (last_t == 0) begin
                total++;
                if (rgb0 !== 24'hABCDEF) begin bad++; $display("FAIL new_solid got=%h exp=abcdef", rgb0); end
            end
        end
        en = 1'b0;
        tick();
        e0 = q0.pop_front(); e1 = q1.pop_front();
        total++;
        if ({obs0, obs1} !== {RST0, RST1}) begin
            bad++; $display("FAIL en_drop got=%h/%h exp=%h/%h", obs0, obs1, RST0, RST1);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL en_low_sb i=%0d got=%h/%h exp=%h/%h", i, obs0, obs1, e0, e1);
            end
        end
        en = 1'b1;
        tick();
        e0 = q0.pop_front(); e1 = q1.pop_front();
        total++;
        if ({de0, fs0, rgb0} !== {1'b1, 1'b1, 24'hABCDEF}) begin
            bad++; $display("FAIL en_restart got=%h exp=%h", {de0, fs0, rgb0}, {1'b1, 1'b1, 24'hABCDEF});
        end
        for (int i = 0; i < 200; i++) begin
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL en_resume_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 50; i++) begin
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({obs0, obs1} !== {RST0, RST1}) begin
            bad++; $display("FAIL rst_async got=%h/%h exp=%h/%h", obs0, obs1, RST0, RST1);
        end
        @(posedge pclk);
        #1;
        rst_n = 1'b1;
        t = 0; sh_pat = 2'd0; sh_col = 24'h0;
        for (int i = 0; i < 300; i++) begin
            tick();
            e0 = q0.pop_front(); e1 = q1.pop_front();
            total++;
            if ({obs0, obs1} !== {e0, e1}) begin
                bad++; $display("FAIL rst_resume_sb t=%0d got=%h/%h exp=%h/%h", last_t, obs0, obs1, e0, e1);
            end
            if (last_t == 0) begin
                total++;
                if ({de0, fs0, rgb0} !== {1'b1, 1'b1, 24'hFFFFFF}) begin
                    bad++; $display("FAIL rst_restart got=%h exp=%h", {de0, fs0, rgb0}, {1'b1, 1'b1, 24'hFFFFFF});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_gradient();
        test_checker();
        test_solid();
        test_enable();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Pixel-clock-domain video timing and test-pattern source that drives the three per-channel TMDS encoders of the HDMI transmitter. It produces hsync, vsync and DE, plus a 24-bit RGB pixel stream aligned to them. Blue-channel encoder ctrl = {vsync, hsync}; red/green channels take their 8-bit slices. Default geometry is 640x480@60 (25.175 MHz pclk).

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high); applies to both syncs
- pclk  in  1  pixel clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low synchronously clears counters and blanks outputs
- pat_sel  in  2  pattern: 0 colour bars, 1 gradient, 2 checkerboard, 3 solid
- solid_rgb  in  24  colour for pattern 3
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- de  out  1  data enable, registered
- rgb  out  24  pixel {R[23:16], G[15:8], B[7:0]}, registered
- frame_start  out  1  one-cycle pulse coinciding with first active pixel of a frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). h_cnt 12 bits, v_cnt 11 bits, both unsigned.
- h_cnt counts 0..H_TOTAL-1, wraps to 0. v_cnt increments when h_cnt wraps; wraps to 0 after V_TOTAL-1.
- Line layout: h_cnt 0..H_ACTIVE-1 active, then FP, SYNC, BP. Same layout vertically on v_cnt.
- h_act = h_cnt < H_ACTIVE; v_act = v_cnt < V_ACTIVE; de_next = h_act & v_act.
- hsync asserted (= SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~SYNC_POL.
- vsync asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], over whole lines; transitions coincide with h_cnt = 0.
- pat_sel and solid_rgb are sampled into shadow registers only when h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1. Mid-frame changes take effect at the next frame. Reset value of the shadows is pattern 0, colour 0.
- Colour bars:
  - BAR_W = H_ACTIVE/8 (integer).
  - Bar index from a bar counter that advances every BAR_W pixels and saturates at 7; the last bar absorbs any remainder.
  - Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Gradient: R = h_cnt[7:0], G = v_cnt[7:0], B = (h_cnt+v_cnt)[7:0] (mod 256).
- Checkerboard: FFFFFF when h_cnt[5]^v_cnt[5], else 000000 (32x32 squares; top-left square black).
- Solid: shadow solid_rgb.
- rgb forced to 0 whenever de_next = 0.
- frame_start_next = (h_cnt == 0) & (v_cnt == 0).
- en low: h_cnt = v_cnt = 0 next cycle. All outputs go to their reset values next cycle and stay there while en is low. On en rising, timing restarts from h_cnt = 0, v_cnt = 0 and frame_start fires on the first enabled output cycle. Shadow registers keep their values while en is low.

## Timing
- Reset values: hsync = vsync = ~SYNC_POL, de = 0, rgb = 0, frame_start = 0, counters 0.
- Latency: every output is registered once from the counter state. The output in cycle n reflects counters in cycle n-1. hsync, vsync, de and rgb are mutually aligned; no relative skew.
- After rst_n deasserts with en high: first de = 1 and frame_start = 1 appear one cycle after the first counting edge.
- Reset asserted mid-frame: outputs go to reset values immediately (async). On release, the frame restarts at 0,0.
- Counter increment and wrap decisions use only the current counter values. No simultaneous-event ambiguity except en, which has priority over counting.

## Test plan
- Defaults, en = 1 after reset:
  - hsync low for exactly 96 cycles every 800 cycles; de high for 640 per line.
  - vsync low for exactly 2x800 cycles every 525x800 = 420000 cycles.
  - 480 de lines per frame; frame_start once per 420000 cycles, on the first de cycle.
- pat_sel = 0: first 80 de pixels FFFFFF, pixels 80..159 FFFF00, ..., pixels 560..639 000000; rgb = 0 during blanking.
- pat_sel = 1: on line 3, pixel 300 → rgb = {8'h2C, 8'h03, 8'h2F}. Pixel 255→256 wraps R from FF to 00.
- pat_sel = 2: (x=0, y=0) → 000000; (32, 0) → FFFFFF; (32, 32) → 000000.
- pat_sel changed 0 → 3 with solid_rgb = 123456 mid-frame: bars continue to frame end; the next frame is all 123456.
- Control events:
  - en dropped at line 100 pixel 200: next cycle de = 0, syncs inactive, rgb = 0. Re-raise: frame_start on the first output cycle.
  - rst_n pulsed mid-line: outputs go to reset values immediately.
  - SYNC_POL = 1 run: sync levels inverted, widths unchanged.
